ex_mem_hs: RTL and testbench
============================

# ex_mem_hs

Parametrised EX→MEM pipeline boundary. It replaces the global stall-vector scheme with a local valid/ready handshake and an optional 2-entry skid buffer, so MEM backpressure does not create a combinational path back into EX. It also carries the multi-cycle MADD/MSUB/DIV temporary state (`hilo`, `cnt`) back to EX while a multi-cycle operation is in progress. It supports a synchronous flush for exceptions and branches.

## Interface
Parameters:
- `DATA_W`, 32, width of the data, HI and LO fields
- `REGADDR_W`, 5, width of the destination register address
- `CNT_W`, 2, width of the multi-cycle step counter

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset: synchronous, active-high
- `flush`  in  1  discard all held entries and clear carry state
- `ex_valid`  in  1  EX presents a packet
- `ex_ready`  out  1  block can accept a packet this cycle
- `ex_wd`  in  REGADDR_W  destination register address
- `ex_wreg`  in  1  register write enable
- `ex_wdata`  in  DATA_W  register write data
- `ex_hi`, `ex_lo`  in  DATA_W  HI/LO write data
- `ex_whilo`  in  1  HI/LO write enable
- `ex_carry_we`  in  1  EX is mid multi-cycle operation; capture `hilo_i`/`cnt_i`
- `hilo_i`  in  2*DATA_W  multi-cycle temporary value from EX
- `cnt_i`  in  CNT_W  multi-cycle step count from EX
- `mem_valid`  out  1  packet present toward MEM
- `mem_ready`  in  1  MEM consumes the packet
- `mem_wd`, `mem_wreg`, `mem_wdata`, `mem_hi`, `mem_lo`, `mem_whilo`  out  packet fields toward MEM
- `hilo_o`  out  2*DATA_W  carried temporary value, returned to EX
- `cnt_o`  out  CNT_W  carried step count, returned to EX
- `level`  out  2  number of entries held (0..2)

## Operation
- Packet = {wd, wreg, wdata, hi, lo, whilo}.
- Accept = `ex_valid && ex_ready`. Pop = `mem_valid && mem_ready`.
- State machine with states EMPTY, ONE, TWO. The main entry drives the `mem_*` outputs; the skid entry is the second slot.
  - EMPTY: on accept → ONE, main ← packet.
  - ONE:
    - accept and no pop → TWO, skid ← packet.
    - pop and no accept → EMPTY.
    - accept and pop → ONE, main ← packet.
  - TWO: on pop → ONE, main ← skid. Accept cannot occur in TWO because `ex_ready` = 0.
- Output rules:
  - `ex_ready` = (state != TWO).
  - `mem_valid` = (state != EMPTY).
  - `level` = 0, 1 or 2 for EMPTY, ONE or TWO.
- Bubble rule: when `mem_valid` = 0, `mem_wd` = 0 (NOP register address), `mem_wreg` = 0, `mem_whilo` = 0, and all data fields = 0.
- Carry rule, in priority order:
  1. rst or flush → clear to 0.
  2. accept → clear to 0; the multi-cycle operation has completed.
  3. `ex_carry_we` → `hilo_o` ← `hilo_i`, `cnt_o` ← `cnt_i`.
  4. Otherwise hold.
- Asserting `ex_carry_we` and `ex_valid` in the same cycle is a protocol violation. The bench asserts on it; the RTL applies priority 2.
- Flush: next state EMPTY, both entries zeroed, carry cleared. Flush wins over a simultaneous accept (packet dropped) and a simultaneous pop.
- Inputs presented while rst is asserted are ignored.

## Timing
- Reset value of every output is 0, except `ex_ready` = 1 (state EMPTY).
- Latency: 1 cycle from accept to `mem_valid`/data visible.
- Throughput: 1 packet per cycle while `mem_ready` = 1.
- `ex_ready` depends only on registered state. No combinational path from `mem_ready` to `ex_ready` when skid is enabled.
- Carry values are visible to EX one cycle after capture.
- After flush, `ex_ready` = 1 and `mem_valid` = 0 in the next cycle.

## Configuration
- `EX_MEM_SKID_EN` defined: 2-entry skid behaviour as specified above.
- `EX_MEM_SKID_EN` undefined:
  - Only EMPTY/ONE exist.
  - `ex_ready` = `!mem_valid || mem_ready` (combinational).
  - `level` never reaches 2.
  - All other behaviour is identical.

## Structure
- Constants in shared `defines.v`: ZeroWord, NOPRegAddr, WriteDisable, state encodings `EM_EMPTY`/`EM_ONE`/`EM_TWO`.
- Packet width is a localparam: REGADDR_W + 3*DATA_W + 2.
- One sub-module, `skid_buf` (parameter W = payload width), holds the state machine and both entries.
- `ex_mem_hs` packs/unpacks the packet, applies the bubble rule, and implements the carry register.

## Test plan
- Reset, then a single packet wd=5, wdata=0x1234 with `mem_ready`=1 → `mem_valid`=1 the next cycle with wd=5, wdata=0x1234; `level` returns to 0 the cycle after.
- Stream 8 packets with `mem_ready`=1 → 8 consecutive `mem_valid` cycles; `ex_ready` stays 1; order preserved.
- Drop `mem_ready` to 0 with 2 packets sent → `level`=2, `ex_ready`=0. Raise `mem_ready` → both delivered in order, then `ex_ready`=1.
- `ex_carry_we`=1 for 3 cycles with cnt_i=1, 2, 3 and hilo_i=0xA_B → `cnt_o`/`hilo_o` follow with 1-cycle lag. Final accept → both clear to 0.
- Flush while `level`=2 and simultaneous accept → next cycle `mem_valid`=0, `level`=0, `mem_wreg`=0, carry=0; dropped packet never appears.
- Build without `EX_MEM_SKID_EN`, `mem_ready`=0 while full → `ex_ready`=0 in the same cycle; `level` never exceeds 1.

Source files
------------

// File: rtl/ex_mem_hs_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ex_mem_hs_pkg : shared state encodings and NOP constants for ex_mem_hs
// Revision 1.0
// ---------------------------------------------------------------------------
package ex_mem_hs_pkg;

  typedef enum logic [1:0] {
    EM_EMPTY = 2'd0,
    EM_ONE   = 2'd1,
    EM_TWO   = 2'd2
  } em_state_t;

  localparam int   ZERO_WORD     = 0;
  localparam int   NOP_REG_ADDR  = 0;
  localparam logic WRITE_DISABLE = 1'b0;

  // Packet = {wd, wreg, wdata, hi, lo, whilo}
  function automatic int pkt_width(input int regaddr_w, input int data_w);
    return regaddr_w + 3 * data_w + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_hs_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ex_mem_hs_if : EX->MEM handshake, packet fields, flush and carry return path
// Revision 1.0
// ---------------------------------------------------------------------------
interface ex_mem_hs_if #(
  parameter int DATA_W    = 32,
  parameter int REGADDR_W = 5,
  parameter int CNT_W     = 2
);
  logic                   flush;
  logic                   ex_valid;
  logic                   ex_ready;
  logic [REGADDR_W-1:0]   ex_wd;
  logic                   ex_wreg;
  logic [DATA_W-1:0]      ex_wdata;
  logic [DATA_W-1:0]      ex_hi;
  logic [DATA_W-1:0]      ex_lo;
  logic                   ex_whilo;
  logic                   ex_carry_we;
  logic [2*DATA_W-1:0]    hilo_i;
  logic [CNT_W-1:0]       cnt_i;
  logic                   mem_valid;
  logic                   mem_ready;
  logic [REGADDR_W-1:0]   mem_wd;
  logic                   mem_wreg;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_hi;
  logic [DATA_W-1:0]      mem_lo;
  logic                   mem_whilo;
  logic [2*DATA_W-1:0]    hilo_o;
  logic [CNT_W-1:0]       cnt_o;
  logic [1:0]             level;

  modport slave (
    input  flush, ex_valid, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
           ex_carry_we, hilo_i, cnt_i, mem_ready,
    output ex_ready, mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo,
           mem_whilo, hilo_o, cnt_o, level
  );

  modport master (
    output flush, ex_valid, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
           ex_carry_we, hilo_i, cnt_i, mem_ready,
    input  ex_ready, mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo,
           mem_whilo, hilo_o, cnt_o, level
  );
endinterface
`default_nettype wire

// File: rtl/ex_mem_hs_skid_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// skid_buf : EMPTY/ONE/TWO valid-ready buffer (TWO only with EX_MEM_SKID_EN)
// Revision 1.0
// ---------------------------------------------------------------------------
module skid_buf
  import ex_mem_hs_pkg::*;
#(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_flush,
  input  wire logic         i_valid,
  output logic              o_ready,
  input  wire logic [W-1:0] i_data,
  output logic              o_valid,
  input  wire logic         i_ready,
  output logic [W-1:0]      o_data,
  output logic              o_accept,
  output logic [1:0]        o_level
);

  em_state_t        r_state;
  em_state_t        w_state_nxt;
  logic [W-1:0]     r_main;
  logic [W-1:0]     r_skid;
  logic             w_push;
  logic             w_pop;
  logic             w_main_from_in;
  logic             w_main_from_skid;
  logic             w_skid_load;

  assign o_valid = (r_state != EM_EMPTY);

`ifdef EX_MEM_SKID_EN
  // Registered-only ready: MEM backpressure is absorbed by the skid slot.
  assign o_ready = (r_state != EM_TWO);
`else
  assign o_ready = !o_valid || i_ready;
`endif

  assign w_push   = i_valid && o_ready;
  assign w_pop    = o_valid && i_ready;
  assign o_accept = w_push;
  assign o_data   = r_main;
  assign o_level  = r_state;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    if (i_flush) begin
      w_state_nxt = EM_EMPTY;
    end else begin
      case (r_state)
        EM_EMPTY: begin
          if (w_push) begin
            w_state_nxt    = EM_ONE;
            w_main_from_in = 1'b1;
          end
        end
        EM_ONE: begin
          if (w_push && !w_pop) begin
            w_state_nxt = EM_TWO;
            w_skid_load = 1'b1;
          end else if (w_push && w_pop) begin
            w_main_from_in = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = EM_EMPTY;
          end
        end
        EM_TWO: begin
          if (w_pop) begin
            w_state_nxt      = EM_ONE;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = EM_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EM_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (i_flush) begin
        r_main <= '0;
        r_skid <= '0;
      end else begin
        if (w_main_from_in) begin
          r_main <= i_data;
        end else if (w_main_from_skid) begin
          r_main <= r_skid;
        end
        if (w_skid_load) begin
          r_skid <= i_data;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_mem_hs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ex_mem_hs : EX->MEM boundary with valid/ready, bubble masking and multi-cycle
//             carry register; define EX_MEM_SKID_EN for the 2-entry skid. Rev 1.0
// ---------------------------------------------------------------------------
module ex_mem_hs
  import ex_mem_hs_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REGADDR_W = 5,
  parameter int CNT_W     = 2
) (
  input  wire logic   clk,
  input  wire logic   rst,
  ex_mem_hs_if.slave  bus
);

  localparam int PKT_W = pkt_width(REGADDR_W, DATA_W);

  logic [PKT_W-1:0]     w_pkt_in;
  logic [PKT_W-1:0]     w_pkt_out;
  logic                 w_valid;
  logic                 w_accept;
  logic [REGADDR_W-1:0] w_wd;
  logic                 w_wreg;
  logic [DATA_W-1:0]    w_wdata;
  logic [DATA_W-1:0]    w_hi;
  logic [DATA_W-1:0]    w_lo;
  logic                 w_whilo;
  logic [2*DATA_W-1:0]  r_hilo;
  logic [CNT_W-1:0]     r_cnt;

  assign w_pkt_in = {bus.ex_wd, bus.ex_wreg, bus.ex_wdata,
                     bus.ex_hi, bus.ex_lo, bus.ex_whilo};

  skid_buf #(
    .W (PKT_W)
  ) u_skid_buf (
    .clk      (clk),
    .rst      (rst),
    .i_flush  (bus.flush),
    .i_valid  (bus.ex_valid),
    .o_ready  (bus.ex_ready),
    .i_data   (w_pkt_in),
    .o_valid  (w_valid),
    .i_ready  (bus.mem_ready),
    .o_data   (w_pkt_out),
    .o_accept (w_accept),
    .o_level  (bus.level)
  );

  assign {w_wd, w_wreg, w_wdata, w_hi, w_lo, w_whilo} = w_pkt_out;

  // Stale entry contents must never leak to MEM as a real write.
  assign bus.mem_valid = w_valid;
  assign bus.mem_wd    = w_valid ? w_wd    : REGADDR_W'(NOP_REG_ADDR);
  assign bus.mem_wreg  = w_valid ? w_wreg  : WRITE_DISABLE;
  assign bus.mem_wdata = w_valid ? w_wdata : DATA_W'(ZERO_WORD);
  assign bus.mem_hi    = w_valid ? w_hi    : DATA_W'(ZERO_WORD);
  assign bus.mem_lo    = w_valid ? w_lo    : DATA_W'(ZERO_WORD);
  assign bus.mem_whilo = w_valid ? w_whilo : WRITE_DISABLE;

  // An accepted packet marks the end of the multi-cycle op, so it clears carry.
  always_ff @(posedge clk) begin
    if (rst || bus.flush || w_accept) begin
      r_hilo <= '0;
      r_cnt  <= '0;
    end else if (bus.ex_carry_we) begin
      r_hilo <= bus.hilo_i;
      r_cnt  <= bus.cnt_i;
    end
  end

  assign bus.hilo_o = r_hilo;
  assign bus.cnt_o  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_hs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ex_mem_hs : directed table plus hand sequences for ex_mem_hs
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_ex_mem_hs;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2;
  localparam logic [63:0] H1 = 64'h0000_000A_0000_000B;
  localparam logic [63:0] H2 = 64'hDEAD_0001_BEEF_0002;

  logic clk = 1'b0;
  logic rst;

  ex_mem_hs_if #(.DATA_W(DW), .REGADDR_W(AW), .CNT_W(CW)) bus();

  ex_mem_hs #(.DATA_W(DW), .REGADDR_W(AW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        mr;
    logic        cwe;
    logic [1:0]  cnt;
    logic [63:0] hilo;
    logic        e_mv;
    logic [4:0]  e_wd;
    logic [31:0] e_wdata;
    logic        e_rdy;
    logic [1:0]  e_lvl;
    logic [1:0]  e_cnt;
    logic [63:0] e_hilo;
  } vec_t;

  vec_t vt[$];
  int n_cmp = 0;
  int n_err = 0;
  int lvl_max = 0;

  always @(negedge clk) begin
    if (!rst && int'(bus.level) > lvl_max) lvl_max = int'(bus.level);
  end

  always @(posedge clk) begin
    if (!rst) assert (!(bus.ex_carry_we && bus.ex_valid))
      else $error("protocol violation: ex_carry_we with ex_valid");
  end

  function automatic logic [31:0] hi_of(input logic [31:0] d);
    return d ^ 32'hFFFF_0000;
  endfunction

  function automatic logic [31:0] lo_of(input logic [31:0] d);
    return ~d;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] wd, input logic [31:0] d);
    bus.ex_valid = v;
    bus.ex_wd    = wd;
    bus.ex_wreg  = 1'b1;
    bus.ex_wdata = d;
    bus.ex_hi    = hi_of(d);
    bus.ex_lo    = lo_of(d);
    bus.ex_whilo = wd[0];
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0);
    bus.ex_carry_we = 1'b0;
    bus.cnt_i       = '0;
    bus.hilo_i      = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic chk_pkt(input string tag, input logic mv, input logic [4:0] wd,
                         input logic [31:0] d);
    chk({tag, ".mem_valid"}, 64'(bus.mem_valid), 64'(mv));
    chk({tag, ".mem_wd"},    64'(bus.mem_wd),    mv ? 64'(wd) : 64'd0);
    chk({tag, ".mem_wreg"},  64'(bus.mem_wreg),  64'(mv));
    chk({tag, ".mem_wdata"}, 64'(bus.mem_wdata), mv ? 64'(d) : 64'd0);
    chk({tag, ".mem_hi"},    64'(bus.mem_hi),    mv ? 64'(hi_of(d)) : 64'd0);
    chk({tag, ".mem_lo"},    64'(bus.mem_lo),    mv ? 64'(lo_of(d)) : 64'd0);
    chk({tag, ".mem_whilo"}, 64'(bus.mem_whilo), 64'(mv & wd[0]));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic [4:0] wd, input logic [31:0] d,
                     input logic mr, input logic cwe, input logic [1:0] cnt,
                     input logic [63:0] hilo, input logic e_mv, input logic [4:0] e_wd,
                     input logic [31:0] e_d, input logic e_rdy, input logic [1:0] e_lvl,
                     input logic [1:0] e_cnt, input logic [63:0] e_hilo);
    vec_t t;
    t.v = v; t.wd = wd; t.wdata = d; t.mr = mr; t.cwe = cwe; t.cnt = cnt; t.hilo = hilo;
    t.e_mv = e_mv; t.e_wd = e_wd; t.e_wdata = e_d; t.e_rdy = e_rdy; t.e_lvl = e_lvl;
    t.e_cnt = e_cnt; t.e_hilo = e_hilo;
    vt.push_back(t);
  endtask

  initial begin
    // Reset with live-looking inputs that must be ignored.
    rst = 1'b1;
    idle();
    bus.mem_ready = 1'b1;
    drive(1'b1, 5'd9, 32'h99);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk_pkt("reset", 1'b0, 5'd0, 32'd0);
    chk("reset.ex_ready", 64'(bus.ex_ready), 64'd1);
    chk("reset.level",    64'(bus.level),    64'd0);
    chk("reset.cnt_o",    64'(bus.cnt_o),    64'd0);
    chk("reset.hilo_o",   bus.hilo_o,        64'd0);
    step();

    // Table: all rows keep mem_ready=1, so skid and non-skid builds agree.
    add(1, 5, 32'h1234, 1, 0, 0, 0,  0, 0, 0,          1, 0, 0, 0);
    add(0, 0, 0,        1, 0, 0, 0,  1, 5, 32'h1234,   1, 1, 0, 0);
    add(0, 0, 0,        1, 0, 0, 0,  0, 0, 0,          1, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      add(1, 5'(k + 1), 32'h100 + 32'(k), 1, 0, 0, 0,
          k > 0, k > 0 ? 5'(k) : 5'd0, k > 0 ? 32'h100 + 32'(k - 1) : 32'd0,
          1, k > 0 ? 2'd1 : 2'd0, 0, 0);
    add(0, 0, 0,        1, 0, 0, 0,  1, 8, 32'h107,    1, 1, 0, 0);
    add(0, 0, 0,        1, 0, 0, 0,  0, 0, 0,          1, 0, 0, 0);
    add(0, 0, 0,        1, 1, 1, H1, 0, 0, 0,          1, 0, 0, 0);
    add(0, 0, 0,        1, 1, 2, H1, 0, 0, 0,          1, 0, 1, H1);
    add(0, 0, 0,        1, 1, 3, H1, 0, 0, 0,          1, 0, 2, H1);
    add(0, 0, 0,        1, 0, 0, 0,  0, 0, 0,          1, 0, 3, H1);
    add(1, 7, 32'h77,   1, 0, 0, 0,  0, 0, 0,          1, 0, 3, H1);
    add(0, 0, 0,        1, 0, 0, 0,  1, 7, 32'h77,     1, 1, 0, 0);
    add(0, 0, 0,        1, 0, 0, 0,  0, 0, 0,          1, 0, 0, 0);

    foreach (vt[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      idle();
      drive(vt[i].v, vt[i].wd, vt[i].wdata);
      bus.mem_ready   = vt[i].mr;
      bus.ex_carry_we = vt[i].cwe;
      bus.cnt_i       = vt[i].cnt;
      bus.hilo_i      = vt[i].hilo;
      @(negedge clk);
      chk_pkt(tag, vt[i].e_mv, vt[i].e_wd, vt[i].e_wdata);
      chk({tag, ".ex_ready"}, 64'(bus.ex_ready), 64'(vt[i].e_rdy));
      chk({tag, ".level"},    64'(bus.level),    64'(vt[i].e_lvl));
      chk({tag, ".cnt_o"},    64'(bus.cnt_o),    64'(vt[i].e_cnt));
      chk({tag, ".hilo_o"},   bus.hilo_o,        vt[i].e_hilo);
      step();
    end

    // Backpressure: two packets offered while MEM stalls.
    idle();
    bus.mem_ready = 1'b0;
    drive(1'b1, 5'h11, 32'hA1);
    @(negedge clk);
    chk("bp0.ex_ready", 64'(bus.ex_ready), 64'd1);
    step();
    drive(1'b1, 5'h12, 32'hA2);
    @(negedge clk);
    chk("bp1.level", 64'(bus.level), 64'd1);
`ifdef EX_MEM_SKID_EN
    chk("bp1.ex_ready", 64'(bus.ex_ready), 64'd1);
    step();
    idle();
    @(negedge clk);
    chk("bp2.level",    64'(bus.level),    64'd2);
    chk("bp2.ex_ready", 64'(bus.ex_ready), 64'd0);
    chk_pkt("bp2", 1'b1, 5'h11, 32'hA1);
    step();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk_pkt("bp3", 1'b1, 5'h11, 32'hA1);
    chk("bp3.ex_ready", 64'(bus.ex_ready), 64'd0);
    step();
    @(negedge clk);
    chk_pkt("bp4", 1'b1, 5'h12, 32'hA2);
    chk("bp4.level",    64'(bus.level),    64'd1);
    chk("bp4.ex_ready", 64'(bus.ex_ready), 64'd1);
    step();
`else
    chk("bp1.ex_ready", 64'(bus.ex_ready), 64'd0);
    step();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("bp2.ex_ready", 64'(bus.ex_ready), 64'd1);
    chk("bp2.level",    64'(bus.level),    64'd1);
    chk_pkt("bp2", 1'b1, 5'h11, 32'hA1);
    step();
    idle();
    @(negedge clk);
    chk_pkt("bp3", 1'b1, 5'h12, 32'hA2);
    chk("bp3.level", 64'(bus.level), 64'd1);
    step();
`endif
    @(negedge clk);
    chk_pkt("bp_end", 1'b0, 5'd0, 32'd0);
    chk("bp_end.level", 64'(bus.level), 64'd0);
    step();

    // Flush with full buffer and live carry; simultaneous packet is dropped.
    idle();
    bus.mem_ready = 1'b0;
    drive(1'b1, 5'h13, 32'hB1);
    step();
`ifdef EX_MEM_SKID_EN
    drive(1'b1, 5'h14, 32'hB2);
    step();
`endif
    idle();
    bus.ex_carry_we = 1'b1;
    bus.cnt_i       = 2'd3;
    bus.hilo_i      = H2;
    step();
    idle();
    bus.flush     = 1'b1;
    bus.mem_ready = 1'b1;
    drive(1'b1, 5'h15, 32'hB3);
    @(negedge clk);
    chk("fl0.cnt_o",  64'(bus.cnt_o), 64'd3);
    chk("fl0.hilo_o", bus.hilo_o,     H2);
    step();
    idle();
    @(negedge clk);
    chk_pkt("fl1", 1'b0, 5'd0, 32'd0);
    chk("fl1.level",    64'(bus.level),    64'd0);
    chk("fl1.ex_ready", 64'(bus.ex_ready), 64'd1);
    chk("fl1.cnt_o",    64'(bus.cnt_o),    64'd0);
    chk("fl1.hilo_o",   bus.hilo_o,        64'd0);
    step();
    @(negedge clk);
    chk_pkt("fl2", 1'b0, 5'd0, 32'd0);
    step();

    // Flush in ONE against an incoming packet.
    idle();
    bus.mem_ready = 1'b0;
    drive(1'b1, 5'h16, 32'hC1);
    step();
    bus.flush = 1'b1;
    drive(1'b1, 5'h17, 32'hC2);
    step();
    idle();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk_pkt("fo1", 1'b0, 5'd0, 32'd0);
    chk("fo1.level", 64'(bus.level), 64'd0);
    step();
    @(negedge clk);
    chk_pkt("fo2", 1'b0, 5'd0, 32'd0);
    step();

`ifdef EX_MEM_SKID_EN
    chk("level_max", 64'(lvl_max), 64'd2);
`else
    chk("level_max", 64'(lvl_max), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
